// File: rtl/kangaroo_pkg.sv
// Shared raster timing constants and types for the video timing generator.
package kangaroo_pkg;

    localparam int unsigned CNT_W     = 9;
    localparam int unsigned MAX_TOTAL = 512;

    localparam int unsigned DEF_H_TOTAL  = 384;
    localparam int unsigned DEF_H_ACTIVE = 256;
    localparam int unsigned DEF_HS_START = 288;
    localparam int unsigned DEF_HS_END   = 320;
    localparam int unsigned DEF_V_TOTAL  = 264;
    localparam int unsigned DEF_V_ACTIVE = 224;
    localparam int unsigned DEF_VS_START = 240;
    localparam int unsigned DEF_VS_END   = 243;

    typedef logic [CNT_W-1:0] raster_cnt_t;

    // True when lo <= cnt < hi.
    function automatic logic in_window(input raster_cnt_t cnt, input int unsigned lo,
                                       input int unsigned hi);
        return (32'(cnt) >= lo) && (32'(cnt) < hi);
    endfunction

endpackage

// File: rtl/ls163.sv
// 4-bit synchronous counter with synchronous clear/load and ripple carry out.
module ls163 (
    input  logic       CLK,
    input  logic       _CLR,
    input  logic       _LOAD,
    input  logic       ENP,
    input  logic       ENT,
    input  logic [3:0] D,
    output logic [3:0] Q,
    output logic       RCO
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Load takes priority over counting and ignores the enables.
    always_comb begin
        q_d = q_q;
        if (!_LOAD) begin
            q_d = D;
        end else if (ENP && ENT) begin
            q_d = q_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!_CLR) begin
            q_q <= 4'h0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q   = q_q;
    assign RCO = ENT & (q_q == 4'hF);

endmodule

// File: rtl/video_timing_gen.sv
// Raster H/V timing generator: cascaded ls163 counters plus registered blank/sync flags
// decoded from the next count so each flag lines up with the count it describes.
module video_timing_gen
    import kangaroo_pkg::*;
#(
    parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned HS_START = DEF_HS_START,
    parameter int unsigned HS_END   = DEF_HS_END,
    parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned VS_START = DEF_VS_START,
    parameter int unsigned VS_END   = DEF_VS_END
) (
    input  logic             CLK,
    input  logic             _CLR,
    input  logic             CE,
    output logic [CNT_W-1:0] H,
    output logic [CNT_W-1:0] V,
    output logic             HBLANK,
    output logic             VBLANK,
    output logic             _HSYNC,
    output logic             _VSYNC,
    output logic             HRC,
    output logic             VRC
);

    localparam int unsigned NSTAGE = 3;
    localparam int unsigned CASC_W = 4 * NSTAGE;

    if (H_TOTAL < 2 || H_TOTAL > MAX_TOTAL || H_ACTIVE > H_TOTAL ||
        HS_START >= HS_END || HS_END > H_TOTAL ||
        V_TOTAL < 2 || V_TOTAL > MAX_TOTAL || V_ACTIVE > V_TOTAL ||
        VS_START >= VS_END || VS_END > V_TOTAL) begin : g_bad_params
        $error("video_timing_gen: illegal raster parameters");
    end

    logic [CASC_W-1:0] h_cnt;
    logic [CASC_W-1:0] v_cnt;
    logic [NSTAGE:0]   h_ent;
    logic [NSTAGE:0]   v_ent;
    logic              h_wrap;
    logic              v_wrap;
    raster_cnt_t       h_nxt;
    raster_cnt_t       v_nxt;

    logic hblank_q, hblank_d;
    logic vblank_q, vblank_d;
    logic hsync_n_q, hsync_n_d;
    logic vsync_n_q, vsync_n_d;

    assign h_ent[0] = 1'b1;
    assign v_ent[0] = 1'b1;

    // Wrap is a synchronous load of zero at TOTAL-1; the V axis steps on the line carry.
    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        ls163 u_h_cnt (
            .CLK   (CLK),
            ._CLR  (_CLR),
            ._LOAD (!HRC),
            .ENP   (CE),
            .ENT   (h_ent[i]),
            .D     (4'h0),
            .Q     (h_cnt[4*i +: 4]),
            .RCO   (h_ent[i+1])
        );
        ls163 u_v_cnt (
            .CLK   (CLK),
            ._CLR  (_CLR),
            ._LOAD (!VRC),
            .ENP   (HRC),
            .ENT   (v_ent[i]),
            .D     (4'h0),
            .Q     (v_cnt[4*i +: 4]),
            .RCO   (v_ent[i+1])
        );
    end

    assign H      = h_cnt[CNT_W-1:0];
    assign V      = v_cnt[CNT_W-1:0];
    assign h_wrap = (32'(H) == H_TOTAL - 1);
    assign v_wrap = (32'(V) == V_TOTAL - 1);
    assign HRC    = CE & h_wrap;
    assign VRC    = HRC & v_wrap;

    // Counts never exceed 9 bits, so the top cascade bits and final carries go nowhere.
    logic unused_cascade;
    assign unused_cascade = ^{h_cnt[CASC_W-1:CNT_W], v_cnt[CASC_W-1:CNT_W],
                              h_ent[NSTAGE], v_ent[NSTAGE]};

    // Count the counters will hold after this edge (reset handled by the flops).
    always_comb begin
        h_nxt = H;
        v_nxt = V;
        if (CE) begin
            h_nxt = h_wrap ? '0 : H + CNT_W'(1);
        end
        if (HRC) begin
            v_nxt = v_wrap ? '0 : V + CNT_W'(1);
        end
    end

    always_comb begin
        hblank_d  = (32'(h_nxt) >= H_ACTIVE);
        vblank_d  = (32'(v_nxt) >= V_ACTIVE);
        hsync_n_d = !in_window(h_nxt, HS_START, HS_END);
        vsync_n_d = !in_window(v_nxt, VS_START, VS_END);
    end

    always_ff @(posedge CLK) begin
        if (!_CLR) begin
            hblank_q  <= 1'b0;
            vblank_q  <= 1'b0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
        end else begin
            hblank_q  <= hblank_d;
            vblank_q  <= vblank_d;
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
        end
    end

    assign HBLANK = hblank_q;
    assign VBLANK = vblank_q;
    assign _HSYNC = hsync_n_q;
    assign _VSYNC = vsync_n_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: three raster configurations share one stimulus stream and are
// checked against an independent count model through an expected-value queue.
module tb_video_timing_gen;
    import kangaroo_pkg::*;

    localparam int NI = 3;

    typedef struct {
        int ht, ha, hss, hse, vt, va, vss, vse;
    } cfg_t;

    typedef struct {
        int   k;
        int   h, v;
        logic hb, vb, hs_n, vs_n;
    } exp_t;

    typedef struct {
        logic clr, ce;
        int   hrc, vrc, h, v;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n;
    logic ce;

    raster_cnt_t h_o [NI];
    raster_cnt_t v_o [NI];
    logic hb_o [NI], vb_o [NI], hs_o [NI], vs_o [NI], hrc_o [NI], vrc_o [NI];

    always #5 clk = ~clk;

    video_timing_gen u_dut_a (
        .CLK(clk), ._CLR(clr_n), .CE(ce), .H(h_o[0]), .V(v_o[0]),
        .HBLANK(hb_o[0]), .VBLANK(vb_o[0]), ._HSYNC(hs_o[0]), ._VSYNC(vs_o[0]),
        .HRC(hrc_o[0]), .VRC(vrc_o[0])
    );

    video_timing_gen #(
        .H_TOTAL(24), .H_ACTIVE(16), .HS_START(18), .HS_END(20),
        .V_TOTAL(20), .V_ACTIVE(14), .VS_START(15), .VS_END(17)
    ) u_dut_b (
        .CLK(clk), ._CLR(clr_n), .CE(ce), .H(h_o[1]), .V(v_o[1]),
        .HBLANK(hb_o[1]), .VBLANK(vb_o[1]), ._HSYNC(hs_o[1]), ._VSYNC(vs_o[1]),
        .HRC(hrc_o[1]), .VRC(vrc_o[1])
    );

    video_timing_gen #(
        .H_TOTAL(2), .H_ACTIVE(1), .HS_START(1), .HS_END(2),
        .V_TOTAL(2), .V_ACTIVE(1), .VS_START(1), .VS_END(2)
    ) u_dut_c (
        .CLK(clk), ._CLR(clr_n), .CE(ce), .H(h_o[2]), .V(v_o[2]),
        .HBLANK(hb_o[2]), .VBLANK(vb_o[2]), ._HSYNC(hs_o[2]), ._VSYNC(vs_o[2]),
        .HRC(hrc_o[2]), .VRC(vrc_o[2])
    );

    cfg_t cfg [NI];
    int   mh [NI];
    int   mv [NI];
    bit   valid = 1'b0;
    exp_t sbq [$];

    int n_checks = 0;
    int n_fail   = 0;

    logic pre_hrc [NI], pre_vrc [NI];
    int   pre_h [NI], pre_v [NI];
    int   hrc_seen [NI], vrc_seen [NI];
    int   vb_seen, vs_seen;

    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t got=%0h exp=%0h", nm, k, $time, got, exp);
        end
    endtask

    task automatic clear_seen();
        for (int k = 0; k < NI; k++) begin
            hrc_seen[k] = 0;
            vrc_seen[k] = 0;
        end
        vb_seen = 0;
        vs_seen = 0;
    endtask

    // One clock: drive at negedge, check carries, push expectations, pop after the edge.
    task automatic cycle(input logic clr_i, input logic ce_i);
        exp_t e;
        @(negedge clk);
        clr_n = clr_i;
        ce    = ce_i;
        #1;
        for (int k = 0; k < NI; k++) begin
            logic eh, ev;
            eh = ce_i && (mh[k] == cfg[k].ht - 1);
            ev = eh && (mv[k] == cfg[k].vt - 1);
            pre_hrc[k] = hrc_o[k];
            pre_vrc[k] = vrc_o[k];
            pre_h[k]   = int'(h_o[k]);
            pre_v[k]   = int'(v_o[k]);
            if (hrc_o[k] === 1'b1) hrc_seen[k]++;
            if (vrc_o[k] === 1'b1) vrc_seen[k]++;
            if (valid) begin
                chk("HRC", k, 32'(hrc_o[k]), 32'(eh));
                chk("VRC", k, 32'(vrc_o[k]), 32'(ev));
            end
            if (!clr_i) begin
                mh[k] = 0;
                mv[k] = 0;
            end else if (ce_i) begin
                if (mh[k] == cfg[k].ht - 1) begin
                    mh[k] = 0;
                    mv[k] = (mv[k] == cfg[k].vt - 1) ? 0 : mv[k] + 1;
                end else begin
                    mh[k] = mh[k] + 1;
                end
            end
        end
        if (!clr_i) valid = 1'b1;
        if (valid) begin
            for (int k = 0; k < NI; k++) begin
                e.k    = k;
                e.h    = mh[k];
                e.v    = mv[k];
                e.hb   = (mh[k] >= cfg[k].ha);
                e.vb   = (mv[k] >= cfg[k].va);
                e.hs_n = !(mh[k] >= cfg[k].hss && mh[k] < cfg[k].hse);
                e.vs_n = !(mv[k] >= cfg[k].vss && mv[k] < cfg[k].vse);
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (vb_o[1] === 1'b1) vb_seen++;
        if (vs_o[1] === 1'b0) vs_seen++;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("H",      e.k, 32'(h_o[e.k]),  32'(e.h));
            chk("V",      e.k, 32'(v_o[e.k]),  32'(e.v));
            chk("HBLANK", e.k, 32'(hb_o[e.k]), 32'(e.hb));
            chk("VBLANK", e.k, 32'(vb_o[e.k]), 32'(e.vb));
            chk("_HSYNC", e.k, 32'(hs_o[e.k]), 32'(e.hs_n));
            chk("_VSYNC", e.k, 32'(vs_o[e.k]), 32'(e.vs_n));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [12];
        int   hb_rise;
        int   hrc_h;
        int   vrc_h, vrc_v;

        cfg[0] = '{384, 256, 288, 320, 264, 224, 240, 243};
        cfg[1] = '{24, 16, 18, 20, 20, 14, 15, 17};
        cfg[2] = '{2, 1, 1, 2, 2, 1, 1, 2};
        for (int k = 0; k < NI; k++) begin
            mh[k] = 0;
            mv[k] = 0;
        end

        // Small raster: {clr, ce, pre-edge HRC, pre-edge VRC, post-edge H, post-edge V}
        tbl[0]  = '{1'b1, 1'b1, 0, 0, 1, 0};
        tbl[1]  = '{1'b1, 1'b1, 1, 0, 0, 1};
        tbl[2]  = '{1'b1, 1'b1, 0, 0, 1, 1};
        tbl[3]  = '{1'b1, 1'b1, 1, 1, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 0, 0, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 0, 0, 1, 0};
        tbl[6]  = '{1'b1, 1'b0, 0, 0, 1, 0};
        tbl[7]  = '{1'b1, 1'b1, 1, 0, 0, 1};
        tbl[8]  = '{1'b1, 1'b1, 0, 0, 1, 1};
        tbl[9]  = '{1'b1, 1'b1, 1, 1, 0, 0};
        tbl[10] = '{1'b0, 1'b1, 0, 0, 0, 0};
        tbl[11] = '{1'b1, 1'b1, 0, 0, 1, 0};

        clr_n = 1'b1;
        ce    = 1'b0;

        // Reset with CE held high
        do_reset();
        for (int k = 0; k < NI; k++) begin
            chk("rst_H", k, 32'(h_o[k]), 32'd0);
            chk("rst_V", k, 32'(v_o[k]), 32'd0);
            chk("rst_HBLANK", k, 32'(hb_o[k]), 32'd0);
            chk("rst_VBLANK", k, 32'(vb_o[k]), 32'd0);
            chk("rst_HSYNC", k, 32'(hs_o[k]), 32'd1);
            chk("rst_VSYNC", k, 32'(vs_o[k]), 32'd1);
        end

        // Table vectors on the 2x2 raster
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].clr, tbl[i].ce);
            chk("tbl_HRC", i, 32'(pre_hrc[2]), 32'(tbl[i].hrc));
            chk("tbl_VRC", i, 32'(pre_vrc[2]), 32'(tbl[i].vrc));
            chk("tbl_H",   i, 32'(h_o[2]),     32'(tbl[i].h));
            chk("tbl_V",   i, 32'(v_o[2]),     32'(tbl[i].v));
        end

        // One full line on the default raster
        do_reset();
        clear_seen();
        hb_rise = -1;
        hrc_h   = -1;
        for (int i = 1; i <= 384; i++) begin
            cycle(1'b1, 1'b1);
            if (pre_hrc[0] === 1'b1) hrc_h = pre_h[0];
            if (hb_rise < 0 && hb_o[0] === 1'b1) hb_rise = i;
        end
        chk("line_hrc_count", 0, 32'(hrc_seen[0]), 32'd1);
        chk("line_hrc_at",    0, 32'(hrc_h),       32'd383);
        chk("line_hb_rise",   0, 32'(hb_rise),     32'd256);
        chk("line_end_H",     0, 32'(h_o[0]),      32'd0);
        chk("line_end_V",     0, 32'(v_o[0]),      32'd1);

        // CE pattern 1,0,0,1 around H=383
        run(382);
        cycle(1'b1, 1'b1);
        chk("ceg_H383", 0, 32'(h_o[0]), 32'd383);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0);
            chk("ceg_hold_HRC", 0, 32'(pre_hrc[0]), 32'd0);
            chk("ceg_hold_H",   0, 32'(h_o[0]),     32'd383);
        end
        cycle(1'b1, 1'b1);
        chk("ceg_wrap_HRC", 0, 32'(pre_hrc[0]), 32'd1);
        chk("ceg_wrap_H",   0, 32'(h_o[0]),     32'd0);
        chk("ceg_wrap_V",   0, 32'(v_o[0]),     32'd2);

        // Full frame on the scaled raster
        do_reset();
        clear_seen();
        vrc_h = -1;
        vrc_v = -1;
        for (int i = 0; i < 24 * 20; i++) begin
            cycle(1'b1, 1'b1);
            if (pre_vrc[1] === 1'b1) begin
                vrc_h = pre_h[1];
                vrc_v = pre_v[1];
            end
        end
        chk("frame_vrc_count", 1, 32'(vrc_seen[1]), 32'd1);
        chk("frame_vrc_H",     1, 32'(vrc_h),       32'd23);
        chk("frame_vrc_V",     1, 32'(vrc_v),       32'd19);
        chk("frame_vblank",    1, 32'(vb_seen),     32'd144);
        chk("frame_vsync",     1, 32'(vs_seen),     32'd48);
        chk("frame_end_H",     1, 32'(h_o[1]),      32'd0);
        chk("frame_end_V",     1, 32'(v_o[1]),      32'd0);
        chk("sweep_vrc_count", 2, 32'(vrc_seen[2]), 32'd120);
        chk("sweep_hrc_count", 2, 32'(hrc_seen[2]), 32'd240);

        // Mid-frame reset while both syncs are active
        do_reset();
        run(16 * 24 + 19);
        chk("mid_H",     1, 32'(h_o[1]),  32'd19);
        chk("mid_V",     1, 32'(v_o[1]),  32'd16);
        chk("mid_HSYNC", 1, 32'(hs_o[1]), 32'd0);
        chk("mid_VSYNC", 1, 32'(vs_o[1]), 32'd0);
        cycle(1'b0, 1'b1);
        chk("mid_rst_H",      1, 32'(h_o[1]),  32'd0);
        chk("mid_rst_V",      1, 32'(v_o[1]),  32'd0);
        chk("mid_rst_HBLANK", 1, 32'(hb_o[1]), 32'd0);
        chk("mid_rst_VBLANK", 1, 32'(vb_o[1]), 32'd0);
        chk("mid_rst_HSYNC",  1, 32'(hs_o[1]), 32'd1);
        chk("mid_rst_VSYNC",  1, 32'(vs_o[1]), 32'd1);
        run(5);
        chk("mid_resume_H", 1, 32'(h_o[1]), 32'd5);
        chk("mid_resume_V", 1, 32'(v_o[1]), 32'd0);

        chk("sb_drained", 0, 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
